// File: rtl/ooo_issue_scheduler.sv
// ooo_issue_scheduler: single-entry issue stage between OoO decode and the
// scalar FUs (0=ARITH 1=MUL 2=DIV 3=LSU). Tracks RAW hazards with a
// per-register pending-write scoreboard. Tracks per-FU in-flight counts.
// Serialising instructions wait in DRAIN until every FU is empty.
// Optional macro SCHED_WAW_CHECK_EN: also stall while the destination
// register has a pending write, so at most one write is pending per register.
module ooo_issue_scheduler #(
  parameter int NUM_FU    = 4,
  parameter int PAYLOAD_W = 128,
  parameter int SB_CNT_W  = 2,
  parameter int OUTST_W   = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  flush,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [NUM_FU-1:0]     dec_fu_sel,
  input  logic [4:0]            dec_rs1,
  input  logic [4:0]            dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [4:0]            dec_rd,
  input  logic                  dec_wen,
  input  logic                  dec_serialize,
  input  logic [PAYLOAD_W-1:0]  dec_payload,
  input  logic [NUM_FU-1:0]     fu_ready,
  output logic [NUM_FU-1:0]     issue_valid,
  output logic [PAYLOAD_W-1:0]  issue_payload,
  input  logic [NUM_FU-1:0]     wb_valid,
  input  logic [5*NUM_FU-1:0]   wb_rd,
  input  logic [NUM_FU-1:0]     wb_wen,
  output logic                  stall_hazard
);

  localparam int NREG  = 32;
  localparam int DEC_W = $clog2(NUM_FU + 1);
  localparam int CW    = ((SB_CNT_W > DEC_W) ? SB_CNT_W : DEC_W) + 1;

  typedef enum logic [1:0] {S_EMPTY, S_DRAIN, S_HELD} state_e;

  typedef struct packed {
    logic [NUM_FU-1:0] sel;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              use1;
    logic              use2;
    logic [4:0]        rd;
    logic              wen;
  } hold_t;

  state_e                          state_q, state_d;
  hold_t                           hold_q, hold_d;
  logic [PAYLOAD_W-1:0]            payload_q, payload_d;
  logic [NREG-1:0][SB_CNT_W-1:0]   sb_cnt_q, sb_cnt_d;
  logic [NUM_FU-1:0][OUTST_W-1:0]  outst_q, outst_d;

  logic [NREG-1:0][DEC_W-1:0]      wb_dec;
  logic [NREG-1:0]                 sb_busy;
  logic                            raw, sat, waw, hazard, fu_rdy, go;
  logic                            accept, sb_inc, drain_done, sb_underflow;
  logic [CW-1:0]                   cnt_ext;

  // Count same-cycle register writebacks per destination (x0 never tracked)
  always_comb begin
    wb_dec = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (wb_valid[i] && wb_wen[i] && wb_rd[i*5 +: 5] != 5'd0)
        wb_dec[wb_rd[i*5 +: 5]] = wb_dec[wb_rd[i*5 +: 5]] + DEC_W'(1);
  end

  // Pending-after-this-cycle's-writebacks: gives the completion bypass
  always_comb begin
    sb_busy = '0;
    for (int r = 0; r < NREG; r++)
      sb_busy[r] = CW'(sb_cnt_q[r]) > CW'(wb_dec[r]);
  end

  // Dispatch qualification for the held instruction
  always_comb begin
    raw    = (hold_q.use1 && hold_q.rs1 != 5'd0 && sb_busy[hold_q.rs1]) ||
             (hold_q.use2 && hold_q.rs2 != 5'd0 && sb_busy[hold_q.rs2]);
    sat    = hold_q.wen && hold_q.rd != 5'd0 && (&sb_cnt_q[hold_q.rd]);
    for (int i = 0; i < NUM_FU; i++)
      if (hold_q.sel[i] && (&outst_q[i])) sat = 1'b1;
`ifdef SCHED_WAW_CHECK_EN
    waw    = hold_q.wen && hold_q.rd != 5'd0 && sb_busy[hold_q.rd];
`else
    waw    = 1'b0;
`endif
    hazard = raw | sat | waw;
    fu_rdy = |(hold_q.sel & fu_ready);
    // A non-one-hot select is held forever (until flush/reset)
    go     = (state_q == S_HELD) && !flush && $onehot(hold_q.sel) && fu_rdy && !hazard;
  end

  assign issue_valid   = go ? hold_q.sel : '0;
  assign issue_payload = payload_q;
  assign dec_ready     = !flush && ((state_q == S_EMPTY) || go);
  assign accept        = dec_valid && dec_ready;
  assign stall_hazard  = (state_q == S_DRAIN) || ((state_q == S_HELD) && hazard);
  assign sb_inc        = go && hold_q.wen && hold_q.rd != 5'd0;

  // Scoreboard update: net of one dispatch increment and N writeback decrements, floor 0
  always_comb begin
    sb_cnt_d     = sb_cnt_q;
    sb_underflow = 1'b0;
    cnt_ext      = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_ext = CW'(sb_cnt_q[r]) + ((sb_inc && hold_q.rd == 5'(r)) ? CW'(1) : CW'(0));
      if (cnt_ext < CW'(wb_dec[r])) sb_underflow = 1'b1;
      sb_cnt_d[r] = (cnt_ext <= CW'(wb_dec[r])) ? '0 : SB_CNT_W'(cnt_ext - CW'(wb_dec[r]));
    end
  end

  // In-flight counters per FU; a writeback on an empty FU is dropped
  always_comb begin
    outst_d = outst_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (go && hold_q.sel[i] && !wb_valid[i])
        outst_d[i] = outst_q[i] + OUTST_W'(1);
      else if (!(go && hold_q.sel[i]) && wb_valid[i] && outst_q[i] != '0)
        outst_d[i] = outst_q[i] - OUTST_W'(1);
    end
    drain_done = (outst_d == '0);
  end

  // Issue register / state sequencing; flush beats accept and dispatch
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    payload_d = payload_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      hold_d    = '{sel: dec_fu_sel, rs1: dec_rs1, rs2: dec_rs2, use1: dec_use_rs1,
                    use2: dec_use_rs2, rd: dec_rd, wen: dec_wen};
      payload_d = dec_payload;
      state_d   = dec_serialize ? S_DRAIN : S_HELD;
    end else begin
      case (state_q)
        S_HELD:  if (go) state_d = S_EMPTY;
        S_DRAIN: if (drain_done) state_d = S_HELD;
        default: state_d = state_q;
      endcase
    end
  end

  // State registers, async clear
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_EMPTY;
      hold_q    <= '0;
      payload_q <= '0;
      sb_cnt_q  <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      payload_q <= payload_d;
      sb_cnt_q  <= sb_cnt_d;
      outst_q   <= outst_d;
    end
  end

  a_issue_onehot: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(issue_valid));
  a_sel_legal:    assert property (@(posedge CLK) disable iff (!nRST)
                                   (dec_valid && dec_ready) |-> $onehot(dec_fu_sel));
  a_sb_underflow: assert property (@(posedge CLK) disable iff (!nRST) !sb_underflow);

  for (genvar g = 0; g < NUM_FU; g++) begin : g_outst_chk
    a_outst_underflow: assert property (@(posedge CLK) disable iff (!nRST)
                                        wb_valid[g] |-> outst_q[g] != '0);
  end

endmodule

// File: tb/tb_ooo_issue_scheduler.sv
// Directed, table-driven bench for ooo_issue_scheduler. Each row is one
// clock: inputs driven after the rising edge, outputs checked at the falling edge.
module tb_ooo_issue_scheduler;

  localparam logic [3:0] A = 4'b0001, M = 4'b0010, D = 4'b0100, L = 4'b1000;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         flush, dec_valid, dec_ready;
  logic [3:0]   dec_fu_sel;
  logic [4:0]   dec_rs1, dec_rs2, dec_rd;
  logic         dec_use_rs1, dec_use_rs2, dec_wen, dec_serialize;
  logic [127:0] dec_payload, issue_payload;
  logic [3:0]   fu_ready, issue_valid, wb_valid, wb_wen;
  logic [19:0]  wb_rd;
  logic         stall_hazard;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ooo_issue_scheduler dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_fu_sel(dec_fu_sel), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd),
    .dec_wen(dec_wen), .dec_serialize(dec_serialize), .dec_payload(dec_payload),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_payload(issue_payload),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .stall_hazard(stall_hazard)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic       ser;
    logic [7:0] pay;
  } dec_t;

  typedef struct packed {
    logic        fl;
    logic        dv;
    dec_t        d;
    logic [3:0]  fr;
    logic [3:0]  wbv;
    logic [19:0] wbrd;
    logic [3:0]  wbw;
    logic        er;
    logic [3:0]  eiv;
    logic        est;
    logic [7:0]  epay;
  } vec_t;

  vec_t tbl[$];

  function automatic dec_t ins(input logic [3:0] sel, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic wen, input logic ser, input logic [7:0] pay);
    dec_t d;
    d = '{sel: sel, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, wen: wen, ser: ser, pay: pay};
    return d;
  endfunction

  function automatic vec_t mk(input logic fl, input logic dv, input dec_t d, input logic [3:0] fr,
                              input logic [3:0] wbv, input logic [19:0] wbrd, input logic [3:0] wbw,
                              input logic er, input logic [3:0] eiv, input logic est,
                              input logic [7:0] ep);
    vec_t v;
    v = '{fl: fl, dv: dv, d: d, fr: fr, wbv: wbv, wbrd: wbrd, wbw: wbw,
          er: er, eiv: eiv, est: est, epay: ep};
    return v;
  endfunction

  // Table row with all FUs ready and a single writeback rd broadcast to every slot
  task automatic add(input logic fl, input logic dv, input dec_t d, input logic [3:0] wbv,
                     input logic [4:0] wrd, input logic ww, input logic er,
                     input logic [3:0] eiv, input logic est, input logic [7:0] ep);
    tbl.push_back(mk(fl, dv, d, 4'hF, wbv, {4{wrd}}, ww ? wbv : 4'h0, er, eiv, est, ep));
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    flush = v.fl; dec_valid = v.dv; dec_fu_sel = v.d.sel;
    dec_rs1 = v.d.rs1; dec_use_rs1 = v.d.u1; dec_rs2 = v.d.rs2; dec_use_rs2 = v.d.u2;
    dec_rd = v.d.rd; dec_wen = v.d.wen; dec_serialize = v.d.ser;
    dec_payload = 128'(v.d.pay);
    fu_ready = v.fr; wb_valid = v.wbv; wb_rd = v.wbrd; wb_wen = v.wbw;
    @(negedge CLK);
    chk({tag, " dec_ready"}, 128'(dec_ready), 128'(v.er));
    chk({tag, " issue_valid"}, 128'(issue_valid), 128'(v.eiv));
    chk({tag, " stall_hazard"}, 128'(stall_hazard), 128'(v.est));
    if (v.eiv != 4'h0) chk({tag, " issue_payload"}, issue_payload, 128'(v.epay));
    @(posedge CLK);
    #1;
  endtask

  dec_t NOP, X, Y, Z;

  initial begin
    NOP = ins(4'h0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    X   = ins(A, 0, 0, 0, 0, 0, 0, 0, 8'h33);
    Y   = ins(A, 13, 1, 0, 0, 14, 1, 0, 8'h42);
    Z   = ins(A, 7, 1, 0, 0, 0, 0, 0, 8'h53);

    // back-to-back independent ARITH, one per cycle, completions one cycle later
    add(0, 0, NOP, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, ins(A, 1, 1, 2, 1, 10, 1, 0, 8'h11), 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, ins(A, 3, 1, 4, 1, 11, 1, 0, 8'h12), 0, 0, 0, 1, A, 0, 8'h11);
    add(0, 1, ins(A, 5, 1, 6, 1, 12, 1, 0, 8'h13), A, 10, 1, 1, A, 0, 8'h12);
    add(0, 0, NOP, A, 11, 1, 1, A, 0, 8'h13);
    add(0, 0, NOP, A, 12, 1, 1, 0, 0, 0);
    // MUL x5 then dependent ARITH, released by the MUL writeback in the same cycle
    add(0, 1, ins(M, 1, 1, 2, 1, 5, 1, 0, 8'h21), 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, ins(A, 5, 1, 0, 0, 6, 1, 0, 8'h22), 0, 0, 0, 1, M, 0, 8'h21);
    add(0, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, NOP, M, 5, 1, 1, A, 0, 8'h22);
    add(0, 0, NOP, A, 6, 1, 1, 0, 0, 0);
    // DIV in flight, CSR drains then dispatches the cycle after the DIV writeback
    add(0, 1, ins(D, 1, 1, 2, 1, 8, 1, 0, 8'h31), 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, ins(A, 0, 0, 0, 0, 9, 1, 1, 8'h32), 0, 0, 0, 1, D, 0, 8'h31);
    add(0, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, X, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, X, D, 8, 1, 0, 0, 1, 0);
    add(0, 1, X, 0, 0, 0, 1, A, 0, 8'h32);
    add(0, 0, NOP, A, 9, 1, 1, A, 0, 8'h33);
    add(0, 0, NOP, A, 0, 0, 1, 0, 0, 0);
    // flush beats dispatch and accept; scoreboard neither bumped nor cleared
    add(0, 1, ins(A, 0, 0, 0, 0, 13, 1, 0, 8'h41), 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, Y, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, Y, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, NOP, 0, 0, 0, 1, A, 0, 8'h42);
    add(0, 1, ins(A, 14, 1, 0, 0, 0, 0, 0, 8'h43), 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, ins(A, 14, 1, 0, 0, 0, 0, 0, 8'h44), 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, NOP, A, 14, 1, 1, A, 0, 8'h44);
    add(0, 0, NOP, A, 0, 0, 1, 0, 0, 0);
    // two LSU loads to x7, then a reader of x7
    add(0, 1, ins(L, 2, 1, 0, 0, 7, 1, 0, 8'h51), 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, ins(L, 3, 1, 0, 0, 7, 1, 0, 8'h52), 0, 0, 0, 1, L, 0, 8'h51);
`ifndef SCHED_WAW_CHECK_EN
    add(0, 0, NOP, 0, 0, 0, 1, L, 0, 8'h52);
    add(0, 1, Z, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, NOP, L, 7, 1, 0, 0, 1, 0);
    add(0, 0, NOP, L, 7, 1, 1, A, 0, 8'h53);
`else
    add(0, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, NOP, L, 7, 1, 1, L, 0, 8'h52);
    add(0, 1, Z, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, NOP, L, 7, 1, 1, A, 0, 8'h53);
`endif
    add(0, 0, NOP, A, 0, 0, 1, 0, 0, 0);
    // LSU in-flight saturation: 7 dispatch, 8th waits until a writeback lands
    add(0, 1, ins(L, 0, 0, 0, 0, 0, 0, 0, 8'h60), 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k < 8; k++)
      add(0, 1, ins(L, 0, 0, 0, 0, 0, 0, 0, 8'h60 + 8'(k)), 0, 0, 0, 1, L, 0, 8'h5F + 8'(k));
    add(0, 0, NOP, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, NOP, L, 0, 0, 0, 0, 1, 0);
    add(0, 0, NOP, 0, 0, 0, 1, L, 0, 8'h67);

    // reset
    nRST = 1'b0;
    apply(mk(0, 0, NOP, 0, 0, 0, 0, 1, 0, 0, 0), "in_reset");
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    chk("reset payload", issue_payload, 128'h0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // async reset while an instruction is held (LSU counter still saturated)
    apply(mk(0, 1, ins(L, 7, 1, 0, 0, 7, 1, 0, 8'h70), 4'h0, 0, 0, 0, 1, 0, 0, 0), "rst_load");
    apply(mk(0, 0, NOP, 4'h0, 0, 0, 0, 0, 0, 1, 0), "rst_held");
    #2 nRST = 1'b0;
    #1;
    chk("midrst issue_valid", 128'(issue_valid), 128'h0);
    chk("midrst dec_ready", 128'(dec_ready), 128'h1);
    chk("midrst stall", 128'(stall_hazard), 128'h0);
    chk("midrst payload", issue_payload, 128'h0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    apply(mk(0, 1, ins(L, 7, 1, 0, 0, 7, 1, 0, 8'h71), 4'hF, 0, 0, 0, 1, 0, 0, 0), "post_rst_load");
    apply(mk(0, 0, NOP, 4'hF, 0, 0, 0, 1, L, 0, 8'h71), "post_rst_issue");

`ifndef SCHED_WAW_CHECK_EN
    // two writebacks to x20 in one cycle clear both pending writes together
    apply(mk(0, 1, ins(M, 0, 0, 0, 0, 20, 1, 0, 8'h81), 4'hF, L, {4{5'd7}}, L, 1, 0, 0, 0), "mw0");
    apply(mk(0, 1, ins(D, 0, 0, 0, 0, 20, 1, 0, 8'h82), 4'hF, 0, 0, 0, 1, M, 0, 8'h81), "mw1");
    apply(mk(0, 1, ins(A, 20, 1, 0, 0, 0, 0, 0, 8'h83), 4'hF, 0, 0, 0, 1, D, 0, 8'h82), "mw2");
    apply(mk(0, 0, NOP, 4'hF, 0, 0, 0, 0, 0, 1, 0), "mw3");
    apply(mk(0, 0, NOP, 4'hF, M | D, {5'd0, 5'd20, 5'd20, 5'd0}, M | D, 1, A, 0, 8'h83), "mw4");
    apply(mk(0, 0, NOP, 4'hF, A, 0, 0, 1, 0, 0, 0), "mw5");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
